// File: rtl/alu_mc.sv
// Multi-cycle, width-generic ALU with valid/ready on both sides and an iterative shift-add multiplier.
// Optional unsigned saturation of the arithmetic opcodes is enabled with `define ALU_SAT_EN.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic [3:0]       ALU_Op_Code,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_RESULT,
  output logic [3:0]       OUT_FLAGS,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a transfer happens on a posedge where valid and ready are both high.
  // IN_READY is high only in IDLE; OUT_VALID only in DONE, where OUT_RESULT/OUT_FLAGS hold until OUT_READY.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_load_out;

  logic [WIDTH-1:0]   w_one;
  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_y;
  logic               w_is_sub;
  logic [WIDTH:0]     w_sum;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_s_res;
  logic               w_s_c;
  logic               w_s_v;

  logic [2*WIDTH-1:0] w_mul_acc_nxt;
  logic [2*WIDTH-1:0] w_mul_first;
  logic               w_mul_hi;
  logic [WIDTH-1:0]   w_mul_res;

  logic [WIDTH-1:0]   w_fin_res;
  logic               w_fin_c;
  logic               w_fin_v;

  assign IN_READY    = (r_state == S_IDLE) && !RESET;
  assign OUT_VALID   = (r_state == S_DONE);
  assign o_dbg_state = r_state;
  assign w_accept    = IN_VALID && IN_READY;
  assign w_is_mul    = (ALU_Op_Code == 4'h2);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      S_MUL:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE: if (OUT_READY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load_out = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  // Shared adder/subtractor covers A+B, A-B and the four increment/decrement ops.
  always_comb begin
    w_one    = {{(WIDTH-1){1'b0}}, 1'b1};
    w_x      = ((ALU_Op_Code == 4'h6) || (ALU_Op_Code == 4'h8)) ? IN_B : IN_A;
    w_y      = ((ALU_Op_Code == 4'h0) || (ALU_Op_Code == 4'h1)) ? IN_B : w_one;
    w_is_sub = (ALU_Op_Code == 4'h1) || (ALU_Op_Code == 4'h7) || (ALU_Op_Code == 4'h8);
    w_sum    = w_is_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
    w_ovf    = w_is_sub ? ((w_x[WIDTH-1] != w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                        : ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]));
  end

  always_comb begin
    w_s_res = '0;
    w_s_c   = 1'b0;
    w_s_v   = 1'b0;
    case (ALU_Op_Code)
      4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h8: begin
        w_s_res = w_sum[WIDTH-1:0];
        w_s_c   = w_sum[WIDTH];
        w_s_v   = w_ovf;
`ifdef ALU_SAT_EN
        if (w_sum[WIDTH]) w_s_res = w_is_sub ? '0 : '1;
`endif
      end
      4'h3: begin
        w_s_res = {IN_A[WIDTH-2:0], 1'b0};
        w_s_c   = IN_A[WIDTH-1];
      end
      4'h4: begin
        w_s_res = {1'b0, IN_A[WIDTH-1:1]};
        w_s_c   = IN_A[0];
      end
      4'h9: w_s_res = {{(WIDTH-1){1'b0}}, (IN_A == IN_B)};
      4'hA: w_s_res = {{(WIDTH-1){1'b0}}, (IN_A > IN_B)};
      4'hB: w_s_res = {{(WIDTH-1){1'b0}}, (IN_A < IN_B)};
      4'hC: w_s_res = IN_A & IN_B;
      4'hD: w_s_res = IN_A | IN_B;
      4'hE: w_s_res = IN_A ^ IN_B;
      4'hF: w_s_res = IN_A;
      default: w_s_res = '0;
    endcase
  end

  // Bit 0 of the multiplier is consumed on the accept edge; bits 1..WIDTH-1 in MUL.
  assign w_mul_first   = IN_B[0] ? {{WIDTH{1'b0}}, IN_A} : '0;
  assign w_mul_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_hi      = |w_mul_acc_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    w_mul_res = w_mul_acc_nxt[WIDTH-1:0];
`ifdef ALU_SAT_EN
    if (w_mul_hi) w_mul_res = '1;
`endif
  end

  always_comb begin
    w_fin_res = w_s_res;
    w_fin_c   = w_s_c;
    w_fin_v   = w_s_v;
    if (r_state == S_MUL) begin
      w_fin_res = w_mul_res;
      w_fin_c   = w_mul_hi;
      w_fin_v   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      OUT_RESULT <= '0;
      OUT_FLAGS  <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_out) begin
        OUT_RESULT <= w_fin_res;
        OUT_FLAGS  <= {(w_fin_res == '0), w_fin_c, w_fin_res[WIDTH-1], w_fin_v};
      end
      if (w_accept && w_is_mul) begin
        r_acc    <= w_mul_first;
        r_mcand  <= {{(WIDTH-1){1'b0}}, IN_A, 1'b0};
        r_mplier <= {1'b0, IN_B[WIDTH-1:1]};
        r_cnt    <= CW'(WIDTH - 1);
      end else if (r_state == S_MUL) begin
        r_acc    <= w_mul_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
      end
    end
  end

endmodule
